// File: rtl/tap_recorder_pkg.sv
// Shared tape definitions: pulse-width defaults in ce ticks, TAP framing, recorder states.
// Pure declarations; no latency or flow-control implications.
// Address width matches the playback side so both paths see one 18-bit tape RAM.
package tap_recorder_pkg;

    localparam int ADDR_W      = 18;
    localparam int CNT_W       = 20;
    localparam int TAP_HDR_LEN = 2;

    localparam int TAPE_PILOT_MIN  = 256;
    localparam int TAPE_T_PILOT_LO = 1700;
    localparam int TAPE_T_PILOT_HI = 2700;
    localparam int TAPE_T_SYNC_HI  = 1000;
    localparam int TAPE_T_BIT      = 2565;
    localparam int TAPE_T_TIMEOUT  = 350000;
    localparam int TAPE_PTR_MAX    = (1 << ADDR_W) - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PILOT,
        ST_SYNC,
        ST_DATA,
        ST_LENLO,
        ST_LENHI
    } tap_state_t;

endpackage

// File: rtl/tape_pulse_meter.sv
// Synchronises mic, detects level changes and measures each half-pulse in ce ticks.
// Latency: edge_vld/width appear 3 clocks after mic changes; timeout is a 1-clock pulse.
// No backpressure: every edge is reported exactly once.
module tape_pulse_meter import tap_recorder_pkg::*; #(
    parameter int T_TIMEOUT = TAPE_T_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             mic,
    output logic             edge_vld,
    output logic [CNT_W-1:0] width,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(T_TIMEOUT - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt;
    logic             level_edge;

    assign level_edge = sync_q[1] ^ level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            level_q  <= 1'b0;
            cnt      <= '0;
            edge_vld <= 1'b0;
            width    <= '0;
            timeout  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], mic};
            level_q  <= sync_q[1];
            edge_vld <= level_edge;
            timeout  <= 1'b0;
            // An edge wins over a simultaneous ce: the pre-increment count is the width.
            if (level_edge) begin
                width <= cnt;
                cnt   <= '0;
            end else if (ce && cnt != '1) begin
                cnt     <= cnt + CNT_W'(1);
                timeout <= (cnt == TMO_LAST);
            end
        end
    end

endmodule

// File: rtl/tap_recorder.sv
// Decodes ROM-standard save pulses from mic and writes a TAP image (LE length + data) to tape RAM.
// Latency: data byte written 1 clock after its last edge; length pair follows block end on 2 clocks.
// No backpressure: RAM accepts one write per clock; we is a single-clock strobe.
module tap_recorder import tap_recorder_pkg::*; #(
    parameter int PILOT_MIN  = TAPE_PILOT_MIN,
    parameter int T_PILOT_LO = TAPE_T_PILOT_LO,
    parameter int T_PILOT_HI = TAPE_T_PILOT_HI,
    parameter int T_SYNC_HI  = TAPE_T_SYNC_HI,
    parameter int T_BIT      = TAPE_T_BIT,
    parameter int T_TIMEOUT  = TAPE_T_TIMEOUT,
    parameter int PTR_MAX    = TAPE_PTR_MAX
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        mic,
    input  logic        rec,
    input  logic        stop,
    output logic [17:0] a,
    output logic [7:0]  q,
    output logic        we,
    output logic        busy,
    output logic [17:0] size,
    output logic [7:0]  blocks,
    output logic        overflow
);

    localparam logic [15:0]       PMIN   = 16'(PILOT_MIN);
    localparam logic [CNT_W-1:0]  W_PLO  = CNT_W'(T_PILOT_LO);
    localparam logic [CNT_W-1:0]  W_PHI  = CNT_W'(T_PILOT_HI);
    localparam logic [CNT_W-1:0]  W_SYNC = CNT_W'(T_SYNC_HI);
    localparam logic [CNT_W-1:0]  W_END  = CNT_W'(2 * T_PILOT_HI);
    localparam logic [CNT_W:0]    W_BIT  = (CNT_W + 1)'(T_BIT);
    localparam logic [ADDR_W-1:0] A_MAX  = ADDR_W'(PTR_MAX);
    localparam logic [ADDR_W:0]   A_LIM  = (ADDR_W + 1)'(PTR_MAX);
    localparam logic [ADDR_W-1:0] HDR    = ADDR_W'(TAP_HDR_LEN);

    logic             edge_vld, timeout;
    logic [CNT_W-1:0] width;

    tape_pulse_meter #(.T_TIMEOUT(T_TIMEOUT)) u_meter (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce       (ce),
        .mic      (mic),
        .edge_vld (edge_vld),
        .width    (width),
        .timeout  (timeout)
    );

    tap_state_t        state;
    logic [ADDR_W-1:0] base, ptr;
    logic [15:0]       pilot_cnt;
    logic [2:0]        bit_cnt;
    logic              half, stop_pend, held_vld;
    logic [CNT_W-1:0]  first_w, held_w;
    logic [6:0]        shreg;

    logic             ev, bit_val, data_end;
    logic [CNT_W-1:0] ew;
    logic [7:0]       byte_val;
    logic [15:0]      blen;

    assign ev       = edge_vld | held_vld;
    assign ew       = held_vld ? held_w : width;
    assign bit_val  = ({1'b0, first_w} + {1'b0, ew}) >= W_BIT;
    assign byte_val = {shreg, bit_val};
    assign blen     = 16'(ptr - base - HDR);
    assign data_end = stop || timeout || (ev && ew >= W_END);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            a         <= '0;
            q         <= '0;
            we        <= 1'b0;
            busy      <= 1'b0;
            size      <= '0;
            blocks    <= '0;
            overflow  <= 1'b0;
            base      <= '0;
            ptr       <= '0;
            pilot_cnt <= '0;
            bit_cnt   <= '0;
            half      <= 1'b0;
            stop_pend <= 1'b0;
            held_vld  <= 1'b0;
            first_w   <= '0;
            held_w    <= '0;
            shreg     <= '0;
        end else begin
            we <= 1'b0;
            // Edges landing while the length pair is written are replayed in PILOT.
            if (state == ST_LENLO || state == ST_LENHI) begin
                if (edge_vld) begin
                    held_vld <= 1'b1;
                    held_w   <= width;
                end
            end else begin
                held_vld <= 1'b0;
            end

            if (rec) begin
                base      <= '0;
                size      <= '0;
                blocks    <= '0;
                overflow  <= 1'b0;
                busy      <= 1'b1;
                pilot_cnt <= '0;
                stop_pend <= 1'b0;
                held_vld  <= 1'b0;
                state     <= ST_PILOT;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_PILOT: begin
                        if (stop) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (timeout) begin
                            pilot_cnt <= '0;
                        end else if (ev) begin
                            if (pilot_cnt >= PMIN && ew < W_SYNC)
                                state <= ST_SYNC;
                            else if (ew >= W_PLO && ew <= W_PHI) begin
                                if (pilot_cnt != '1)
                                    pilot_cnt <= pilot_cnt + 16'd1;
                            end else
                                pilot_cnt <= '0;
                        end
                    end
                    ST_SYNC: begin
                        if (stop) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (timeout) begin
                            pilot_cnt <= '0;
                            state     <= ST_PILOT;
                        end else if (ev) begin
                            pilot_cnt <= '0;
                            // No room for even one data byte after the length header.
                            if (({1'b0, base} + (ADDR_W + 1)'(TAP_HDR_LEN)) > A_LIM) begin
                                overflow <= 1'b1;
                                busy     <= 1'b0;
                                state    <= ST_IDLE;
                            end else begin
                                ptr     <= base + HDR;
                                bit_cnt <= '0;
                                half    <= 1'b0;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (data_end) begin
                            stop_pend <= stop;
                            if (ptr == base + HDR) begin
                                pilot_cnt <= '0;
                                busy      <= !stop;
                                state     <= stop ? ST_IDLE : ST_PILOT;
                            end else
                                state <= ST_LENLO;
                        end else if (ev) begin
                            if (!half) begin
                                first_w <= ew;
                                half    <= 1'b1;
                            end else begin
                                half    <= 1'b0;
                                shreg   <= byte_val[6:0];
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    we <= 1'b1;
                                    a  <= ptr;
                                    q  <= byte_val;
                                    if (ptr == A_MAX) begin
                                        overflow <= 1'b1;
                                        busy     <= 1'b0;
                                        state    <= ST_IDLE;
                                    end else
                                        ptr <= ptr + ADDR_W'(1);
                                end
                            end
                        end
                    end
                    ST_LENLO: begin
                        if (stop)
                            stop_pend <= 1'b1;
                        we    <= 1'b1;
                        a     <= base;
                        q     <= blen[7:0];
                        state <= ST_LENHI;
                    end
                    ST_LENHI: begin
                        we        <= 1'b1;
                        a         <= base + ADDR_W'(1);
                        q         <= blen[15:8];
                        base      <= ptr;
                        size      <= ptr;
                        pilot_cnt <= '0;
                        if (blocks != 8'hFF)
                            blocks <= blocks + 8'd1;
                        if (stop || stop_pend) begin
                            stop_pend <= 1'b0;
                            busy      <= 1'b0;
                            state     <= ST_IDLE;
                        end else
                            state <= ST_PILOT;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tap_recorder.sv
// Directed bench for tap_recorder with tick-scaled pulse timing (ce every clock) and a small RAM image.
module tb_tap_recorder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b1;
    logic        mic = 1'b0;
    logic        rec = 1'b0;
    logic        stop = 1'b0;
    logic [17:0] a;
    logic [7:0]  q;
    logic        we;
    logic        busy;
    logic [17:0] size;
    logic [7:0]  blocks;
    logic        overflow;

    logic [7:0] mem [0:31];
    int n_wr  = 0;
    int n_chk = 0;
    int n_err = 0;

    // Scaled timing: pilot half 11 clk (w=10), sync half 3 (w=2), bit halves 4/8 (w=3/7), long 40.
    tap_recorder #(
        .PILOT_MIN  (256),
        .T_PILOT_LO (8),
        .T_PILOT_HI (14),
        .T_SYNC_HI  (5),
        .T_BIT      (10),
        .T_TIMEOUT  (400),
        .PTR_MAX    (29)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ce       (ce),
        .mic      (mic),
        .rec      (rec),
        .stop     (stop),
        .a        (a),
        .q        (q),
        .we       (we),
        .busy     (busy),
        .size     (size),
        .blocks   (blocks),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (we) begin
            if (a < 18'd32)
                mem[a[4:0]] = q;
            n_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic toggle(input int n);
        mic = ~mic;
        tick(n);
    endtask

    task automatic pilot(input int n);
        repeat (n) toggle(11);
        toggle(3);
        toggle(3);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            toggle(b[i] ? 8 : 4);
            toggle(b[i] ? 8 : 4);
        end
    endtask

    task automatic end_long();
        toggle(40);
        toggle(20);
    endtask

    task automatic pulse_rec();
        rec = 1'b1;
        tick(1);
        rec = 1'b0;
    endtask

    initial begin
        tick(3);
        check("rst_a", 32'(a), 0);
        check("rst_q", 32'(q), 0);
        check("rst_we", 32'(we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_size", 32'(size), 0);
        check("rst_blocks", 32'(blocks), 0);
        check("rst_ovf", 32'(overflow), 0);
        reset_n = 1'b1;
        tick(3);

        // Single 5-byte block closed by timeout.
        n_wr = 0;
        pulse_rec();
        check("rec_busy", 32'(busy), 1);
        pilot(300);
        send_bits(8'hA5, 8); send_bits(8'h5A, 8); send_bits(8'hFF, 8);
        send_bits(8'h00, 8); send_bits(8'h81, 8);
        toggle(450);
        check("t1_len_lo", 32'(mem[0]), 32'h05);
        check("t1_len_hi", 32'(mem[1]), 32'h00);
        check("t1_d0", 32'(mem[2]), 32'hA5);
        check("t1_d2", 32'(mem[4]), 32'hFF);
        check("t1_d4", 32'(mem[6]), 32'h81);
        check("t1_size", 32'(size), 7);
        check("t1_blocks", 32'(blocks), 1);
        check("t1_nwr", 32'(n_wr), 7);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        tick(2);
        check("stop_busy", 32'(busy), 0);
        check("stop_size", 32'(size), 7);

        // Header + data block pair, then a third block running into the end of RAM.
        n_wr = 0;
        pulse_rec();
        pilot(300);
        for (int i = 0; i < 19; i++) send_bits(8'((i * 13 + 5) & 255), 8);
        end_long();
        pilot(300);
        for (int i = 0; i < 3; i++) send_bits(8'(8'hC0 + i), 8);
        end_long();
        check("t2_len0", 32'(mem[0]), 32'h13);
        check("t2_len0_hi", 32'(mem[1]), 32'h00);
        check("t2_d0", 32'(mem[2]), 32'h05);
        check("t2_d18", 32'(mem[20]), 32'hEF);
        check("t2_len1", 32'(mem[21]), 32'h03);
        check("t2_len1_hi", 32'(mem[22]), 32'h00);
        check("t2_b1d0", 32'(mem[23]), 32'hC0);
        check("t2_b1d2", 32'(mem[25]), 32'hC2);
        check("t2_size", 32'(size), 26);
        check("t2_blocks", 32'(blocks), 2);
        pilot(300);
        send_bits(8'h5A, 8); send_bits(8'hA6, 8); send_bits(8'h99, 8); send_bits(8'h42, 8);
        end_long();
        check("ovf_d28", 32'(mem[28]), 32'h5A);
        check("ovf_d29", 32'(mem[29]), 32'hA6);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_busy", 32'(busy), 0);
        check("ovf_size", 32'(size), 26);
        check("ovf_blocks", 32'(blocks), 2);
        check("ovf_nwr", 32'(n_wr), 28);

        // Short pilot is rejected; a 260-pulse pilot just clears the minimum.
        n_wr = 0;
        pulse_rec();
        check("t3_ovf_clr", 32'(overflow), 0);
        pilot(200);
        send_bits(8'hFF, 8); send_bits(8'h12, 8);
        end_long();
        check("t3_nwr", 32'(n_wr), 0);
        check("t3_size0", 32'(size), 0);
        pilot(260);
        send_bits(8'h3C, 8);
        end_long();
        check("t3_len", 32'(mem[0]), 1);
        check("t3_d0", 32'(mem[2]), 32'h3C);
        check("t3_size", 32'(size), 3);
        check("t3_blocks", 32'(blocks), 1);

        // Trailing partial byte is dropped; next block starts right after.
        n_wr = 0;
        pulse_rec();
        pilot(300);
        for (int i = 0; i < 8; i++) send_bits(8'(8'h10 + i), 8);
        send_bits(8'hF8, 5);
        end_long();
        check("t4_len", 32'(mem[0]), 8);
        check("t4_d7", 32'(mem[9]), 32'h17);
        check("t4_size", 32'(size), 10);
        pilot(300);
        send_bits(8'h66, 8);
        end_long();
        check("t4_len2", 32'(mem[10]), 1);
        check("t4_d2", 32'(mem[12]), 32'h66);
        check("t4_size2", 32'(size), 13);
        check("t4_blocks", 32'(blocks), 2);
        check("t4_nwr", 32'(n_wr), 13);

        // rec in the middle of a block restarts the image at address 0.
        pilot(300);
        send_bits(8'h77, 8);
        send_bits(8'h80, 3);
        pulse_rec();
        check("rr_blocks", 32'(blocks), 0);
        check("rr_size", 32'(size), 0);
        check("rr_busy", 32'(busy), 1);
        pilot(300);
        send_bits(8'h11, 8);
        end_long();
        check("rr_len", 32'(mem[0]), 1);
        check("rr_d0", 32'(mem[2]), 32'h11);
        check("rr_size3", 32'(size), 3);
        check("rr_blocks1", 32'(blocks), 1);

        // Asynchronous reset in the middle of DATA.
        pilot(300);
        send_bits(8'h22, 8);
        send_bits(8'hA0, 3);
        check("pre_rst_a", 32'(a), 5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_a", 32'(a), 0);
        check("mid_rst_q", 32'(q), 0);
        check("mid_rst_we", 32'(we), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_size", 32'(size), 0);
        check("mid_rst_blocks", 32'(blocks), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
